// File: rtl/obi_axi4l_master.sv
// obi_axi4l_master: bridges the core's data-side request/grant bus onto one
// AXI4-Lite master port. One transaction is outstanding at a time. The core
// gets a one-cycle rvalid pulse carrying read data and an error flag.
//
// Handshake semantics: every AXI channel transfers on a rising clk edge where
// valid && ready are both high. A valid, once raised, is held with stable
// payload until that edge. Ready outputs (bready/rready) are high only while
// the bridge is waiting for that response. The core side is granted
// combinationally while idle, and the request fields are captured on that edge.
module obi_axi4l_master #(
  parameter int          ADDR_W = 32,
  parameter logic [2:0]  PROT   = 3'b000
) (
  input  logic              clk,
  input  logic              rst,
  // core data port
  input  logic              data_req_i,
  output logic              data_gnt_o,
  input  logic              data_we_i,
  input  logic [3:0]        data_be_i,
  input  logic [ADDR_W-1:0] data_addr_i,
  input  logic [31:0]       data_wdata_i,
  output logic              data_rvalid_o,
  output logic [31:0]       data_rdata_o,
  output logic              data_err_o,
  // AXI4-Lite write address
  output logic              m_awvalid,
  input  logic              m_awready,
  output logic [ADDR_W-1:0] m_awaddr,
  output logic [2:0]        m_awprot,
  // AXI4-Lite write data
  output logic              m_wvalid,
  input  logic              m_wready,
  output logic [31:0]       m_wdata,
  output logic [3:0]        m_wstrb,
  // AXI4-Lite write response
  input  logic              m_bvalid,
  output logic              m_bready,
  input  logic [1:0]        m_bresp,
  // AXI4-Lite read address
  output logic              m_arvalid,
  input  logic              m_arready,
  output logic [ADDR_W-1:0] m_araddr,
  output logic [2:0]        m_arprot,
  // AXI4-Lite read data
  input  logic              m_rvalid,
  output logic              m_rready,
  input  logic [31:0]       m_rdata,
  input  logic [1:0]        m_rresp,
  // debug: current FSM state (0 = IDLE)
  output logic [2:0]        state_o
);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_WR    = 3'd1,
    S_WRESP = 3'd2,
    S_RD    = 3'd3,
    S_RRESP = 3'd4,
    S_RSP   = 3'd5
  } state_e;

  state_e              state_q;
  logic [ADDR_W-3:0]   addr_q;      // word address; byte offset is dropped
  logic [3:0]          be_q;
  logic [31:0]         wdata_q;
  logic [31:0]         rdata_q;
  logic                err_q;       // only ever set while in S_RSP
  logic                awvalid_q;
  logic                wvalid_q;
  logic                arvalid_q;
  logic                bready_q;
  logic                rready_q;
  logic                rvalid_q;

  // The byte offset never reaches AXI; addresses are always word aligned.
  logic unused_addr_bits;
  assign unused_addr_bits = ^data_addr_i[1:0];

  assign data_gnt_o    = data_req_i && (state_q == S_IDLE);
  assign data_rvalid_o = rvalid_q;
  assign data_rdata_o  = rdata_q;
  assign data_err_o    = err_q;

  assign m_awvalid = awvalid_q;
  assign m_awaddr  = {addr_q, 2'b00};
  assign m_awprot  = PROT;
  assign m_wvalid  = wvalid_q;
  assign m_wdata   = wdata_q;
  assign m_wstrb   = be_q;
  assign m_bready  = bready_q;
  assign m_arvalid = arvalid_q;
  assign m_araddr  = {addr_q, 2'b00};
  assign m_arprot  = PROT;
  assign m_rready  = rready_q;
  assign state_o   = state_q;

  // Transaction FSM with all handshake outputs held in registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= S_IDLE;
      addr_q    <= '0;
      be_q      <= '0;
      wdata_q   <= '0;
      rdata_q   <= '0;
      err_q     <= 1'b0;
      awvalid_q <= 1'b0;
      wvalid_q  <= 1'b0;
      arvalid_q <= 1'b0;
      bready_q  <= 1'b0;
      rready_q  <= 1'b0;
      rvalid_q  <= 1'b0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (data_req_i) begin
            addr_q  <= data_addr_i[ADDR_W-1:2];
            be_q    <= data_be_i;
            wdata_q <= data_wdata_i;
            if (data_we_i) begin
              state_q   <= S_WR;
              awvalid_q <= 1'b1;
              wvalid_q  <= 1'b1;
            end else begin
              state_q   <= S_RD;
              arvalid_q <= 1'b1;
            end
          end
        end
        S_WR: begin
          // Each channel retires on its own handshake; order is free.
          if (m_awready) awvalid_q <= 1'b0;
          if (m_wready)  wvalid_q  <= 1'b0;
          if ((!awvalid_q || m_awready) && (!wvalid_q || m_wready)) begin
            state_q  <= S_WRESP;
            bready_q <= 1'b1;
          end
        end
        S_WRESP: begin
          if (m_bvalid) begin
            err_q    <= (m_bresp != 2'b00);
            bready_q <= 1'b0;
            rvalid_q <= 1'b1;
            state_q  <= S_RSP;
          end
        end
        S_RD: begin
          if (m_arready) begin
            arvalid_q <= 1'b0;
            rready_q  <= 1'b1;
            state_q   <= S_RRESP;
          end
        end
        S_RRESP: begin
          if (m_rvalid) begin
            rdata_q  <= m_rdata;
            err_q    <= (m_rresp != 2'b00);
            rready_q <= 1'b0;
            rvalid_q <= 1'b1;
            state_q  <= S_RSP;
          end
        end
        S_RSP: begin
          rvalid_q <= 1'b0;
          err_q    <= 1'b0;
          state_q  <= S_IDLE;
        end
        default: begin
          state_q <= S_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_obi_axi4l_master.sv
// Bench for obi_axi4l_master: a transaction table drives the core port and a
// reactive AXI slave. A timeline model predicts, cycle by cycle, every
// handshake output from the table using plain arithmetic.
module tb_obi_axi4l_master;

  localparam int NC        = 80;   // modelled cycles
  localparam int NT        = 10;   // transactions
  localparam int END_C     = 72;   // driver stops here
  localparam int PHANTOM_C = 14;   // one-cycle request withdrawn while busy

  typedef struct {
    logic        we;
    logic [3:0]  be;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] rdata;
    logic [1:0]  resp;
    int          start;
    int          aw_wait;
    int          w_wait;
    int          ar_wait;
    int          b_wait;
    int          r_wait;
    int          abort_at;
  } txn_t;

  // clock/reset block
  logic clk = 1'b0;
  logic rst = 1'b1;
  int   cyc = 0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // DUT signals
  logic        data_req_i = 1'b0, data_we_i = 1'b0;
  logic [3:0]  data_be_i = 4'h0;
  logic [31:0] data_addr_i = '0, data_wdata_i = '0;
  logic        data_gnt_o, data_rvalid_o, data_err_o;
  logic [31:0] data_rdata_o;
  logic        m_awvalid, m_wvalid, m_bready, m_arvalid, m_rready;
  logic        m_awready = 1'b0, m_wready = 1'b0, m_bvalid = 1'b0;
  logic        m_arready = 1'b0, m_rvalid = 1'b0;
  logic [31:0] m_awaddr, m_araddr, m_wdata;
  logic [3:0]  m_wstrb;
  logic [2:0]  m_awprot, m_arprot, state_o;
  logic [1:0]  m_bresp = 2'b00, m_rresp = 2'b00;
  logic [31:0] m_rdata = '0;

  obi_axi4l_master #(.ADDR_W(32), .PROT(3'b000)) dut (
    .clk(clk), .rst(rst),
    .data_req_i(data_req_i), .data_gnt_o(data_gnt_o), .data_we_i(data_we_i),
    .data_be_i(data_be_i), .data_addr_i(data_addr_i), .data_wdata_i(data_wdata_i),
    .data_rvalid_o(data_rvalid_o), .data_rdata_o(data_rdata_o), .data_err_o(data_err_o),
    .m_awvalid(m_awvalid), .m_awready(m_awready), .m_awaddr(m_awaddr), .m_awprot(m_awprot),
    .m_wvalid(m_wvalid), .m_wready(m_wready), .m_wdata(m_wdata), .m_wstrb(m_wstrb),
    .m_bvalid(m_bvalid), .m_bready(m_bready), .m_bresp(m_bresp),
    .m_arvalid(m_arvalid), .m_arready(m_arready), .m_araddr(m_araddr), .m_arprot(m_arprot),
    .m_rvalid(m_rvalid), .m_rready(m_rready), .m_rdata(m_rdata), .m_rresp(m_rresp),
    .state_o(state_o)
  );

  // transaction table and per-cycle expectations
  txn_t        tx[NT];
  logic        exp_gnt[NC], exp_rv[NC], exp_err[NC], exp_idle[NC];
  logic        exp_awv[NC], exp_wv[NC], exp_arv[NC], exp_br[NC], exp_rr[NC];
  logic        rst_at[NC], upd[NC];
  logic [31:0] upd_val[NC], exp_rdata[NC];
  int          exp_tx[NC];
  int          sl_idx = 0;
  int          n_checks = 0;
  int          n_errors = 0;

  // scoreboard check
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s cycle %0d: got %h expected %h", name, cyc, act, exp);
    end
  endtask

  task automatic add(input int i, input logic we, input logic [3:0] be,
                     input logic [31:0] addr, input logic [31:0] wdata,
                     input logic [31:0] rdata, input logic [1:0] resp, input int start,
                     input int aww, input int ww, input int arw, input int bw,
                     input int rw, input int abort_at);
    tx[i].we = we;   tx[i].be = be;   tx[i].addr = addr; tx[i].wdata = wdata;
    tx[i].rdata = rdata; tx[i].resp = resp; tx[i].start = start;
    tx[i].aw_wait = aww; tx[i].w_wait = ww; tx[i].ar_wait = arw;
    tx[i].b_wait = bw;   tx[i].r_wait = rw; tx[i].abort_at = abort_at;
  endtask

  // Timeline model: each transaction occupies the bus from its grant until its
  // response cycle; waits add directly to the handshake cycles.
  task automatic build_model();
    int free_c, g, a, w, hs, bc, ar, rc, rv, lim;
    logic [31:0] cur;
    for (int c = 0; c < NC; c++) begin
      exp_gnt[c] = 0; exp_rv[c] = 0; exp_err[c] = 0; exp_idle[c] = 1;
      exp_awv[c] = 0; exp_wv[c] = 0; exp_arv[c] = 0; exp_br[c] = 0; exp_rr[c] = 0;
      rst_at[c] = (c <= 2); upd[c] = 0; upd_val[c] = '0; exp_tx[c] = 0;
    end
    free_c = 0;
    for (int i = 0; i < NT; i++) begin
      g = (tx[i].start > free_c) ? tx[i].start : free_c;
      exp_gnt[g] = 1;
      a = 0; w = 0; hs = 0; bc = 0; ar = 0; rc = 0;
      if (tx[i].we) begin
        a  = g + 1 + tx[i].aw_wait;
        w  = g + 1 + tx[i].w_wait;
        hs = (a > w) ? a : w;
        bc = hs + 1 + tx[i].b_wait;
        rv = bc + 1;
      end else begin
        ar = g + 1 + tx[i].ar_wait;
        rc = ar + 1 + tx[i].r_wait;
        rv = rc + 1;
      end
      lim = (tx[i].abort_at >= 0) ? tx[i].abort_at : rv;
      for (int c = g + 1; c <= lim; c++) begin
        exp_idle[c] = 0;
        exp_tx[c]   = i;
        if (tx[i].we) begin
          exp_awv[c] = (c <= a);
          exp_wv[c]  = (c <= w);
          exp_br[c]  = (c > hs) && (c <= bc);
        end else begin
          exp_arv[c] = (c <= ar);
          exp_rr[c]  = (c > ar) && (c <= rc);
        end
      end
      if (tx[i].abort_at >= 0) begin
        rst_at[tx[i].abort_at] = 1;
      end else begin
        exp_rv[rv]  = 1;
        exp_err[rv] = (tx[i].resp != 2'b00);
        if (!tx[i].we) begin
          upd[rv]     = 1;
          upd_val[rv] = tx[i].rdata;
        end
      end
      free_c = lim + 1;
    end
    cur = '0;
    for (int c = 0; c < NC; c++) begin
      if (c > 0 && rst_at[c-1]) cur = '0;
      if (upd[c]) cur = upd_val[c];
      exp_rdata[c] = cur;
    end
  endtask

  // reactive AXI slave; drives junk responses whenever the ready is low
  int aw_cnt = 0, w_cnt = 0, ar_cnt = 0, b_cnt = 0, r_cnt = 0;
  always @(negedge clk) begin
    if (m_awvalid) begin
      m_awready = (aw_cnt >= tx[sl_idx].aw_wait);
      aw_cnt = m_awready ? 0 : aw_cnt + 1;
    end else begin
      m_awready = 1'b0; aw_cnt = 0;
    end
    if (m_wvalid) begin
      m_wready = (w_cnt >= tx[sl_idx].w_wait);
      w_cnt = m_wready ? 0 : w_cnt + 1;
    end else begin
      m_wready = 1'b0; w_cnt = 0;
    end
    if (m_arvalid) begin
      m_arready = (ar_cnt >= tx[sl_idx].ar_wait);
      ar_cnt = m_arready ? 0 : ar_cnt + 1;
    end else begin
      m_arready = 1'b0; ar_cnt = 0;
    end
    if (m_bready) begin
      m_bvalid = (b_cnt >= tx[sl_idx].b_wait);
      m_bresp  = m_bvalid ? tx[sl_idx].resp : 2'b00;
      b_cnt = m_bvalid ? 0 : b_cnt + 1;
    end else begin
      m_bvalid = 1'b1; m_bresp = 2'b10; b_cnt = 0;
    end
    if (m_rready) begin
      m_rvalid = (r_cnt >= tx[sl_idx].r_wait);
      m_rdata  = m_rvalid ? tx[sl_idx].rdata : 32'hCAFE_0000;
      m_rresp  = m_rvalid ? tx[sl_idx].resp : 2'b00;
      r_cnt = m_rvalid ? 0 : r_cnt + 1;
    end else begin
      m_rvalid = 1'b1; m_rdata = 32'hDEAD_0000 | 32'(cyc); m_rresp = 2'b11; r_cnt = 0;
    end
  end

  // compare process: model every cycle plus hand-computed pins
  always @(negedge clk) begin
    #2;
    if (cyc >= 1 && cyc < NC) begin
      chk("gnt",     32'(data_gnt_o),      32'(exp_gnt[cyc]));
      chk("rvalid",  32'(data_rvalid_o),   32'(exp_rv[cyc]));
      chk("err",     32'(data_err_o),      32'(exp_err[cyc]));
      chk("rdata",   data_rdata_o,         exp_rdata[cyc]);
      chk("awvalid", 32'(m_awvalid),       32'(exp_awv[cyc]));
      chk("wvalid",  32'(m_wvalid),        32'(exp_wv[cyc]));
      chk("arvalid", 32'(m_arvalid),       32'(exp_arv[cyc]));
      chk("bready",  32'(m_bready),        32'(exp_br[cyc]));
      chk("rready",  32'(m_rready),        32'(exp_rr[cyc]));
      chk("idle",    32'(state_o == 3'd0), 32'(exp_idle[cyc]));
      chk("prot",    32'({m_awprot, m_arprot}), 32'(0));
      if (exp_awv[cyc]) chk("awaddr", m_awaddr, tx[exp_tx[cyc]].addr & 32'hFFFF_FFFC);
      if (exp_wv[cyc]) begin
        chk("wdata", m_wdata, tx[exp_tx[cyc]].wdata);
        chk("wstrb", 32'(m_wstrb), 32'(tx[exp_tx[cyc]].be));
      end
      if (exp_arv[cyc]) chk("araddr", m_araddr, tx[exp_tx[cyc]].addr & 32'hFFFF_FFFC);
      case (cyc)
        5: begin
          chk("lit_awaddr", m_awaddr, 32'h1000_0000);
          chk("lit_wstrb", 32'(m_wstrb), 32'h3);
          chk("lit_wdata", m_wdata, 32'hDEAD_BEEF);
        end
        7:  chk("lit_wr_rvalid", 32'({data_rvalid_o, data_err_o}), 32'h2);
        18: chk("lit_rd_stall", {data_rdata_o[30:0], data_rvalid_o}, {31'h0000_00A5, 1'b1});
        22: chk("lit_split_wvalid", 32'({m_wvalid, m_awvalid}), 32'h1);
        24: chk("lit_split_awvalid", 32'({m_awvalid, m_bready}), 32'h2);
        33: begin
          chk("lit_rerr", 32'({data_rvalid_o, data_err_o}), 32'h3);
          chk("lit_rerr_data", data_rdata_o, 32'h1234_5678);
        end
        41: chk("lit_berr", 32'({data_rvalid_o, data_err_o}), 32'h3);
        48: chk("lit_reset_valids", 32'({m_awvalid, m_wvalid, data_rvalid_o}), 32'h0);
        54, 58, 62: chk("lit_b2b_gnt", 32'({data_gnt_o, data_rvalid_o}), 32'h2);
        57, 61, 65: chk("lit_b2b_rvalid", 32'({data_gnt_o, data_rvalid_o}), 32'h1);
        default: ;
      endcase
    end
  end

  // driver: walks the table, one request at a time
  initial begin
    int  i;
    logic phantom;
    add(0, 1, 4'b0011, 32'h1000_0003, 32'hDEAD_BEEF, 32'h0,         2'b00,  4, 0,  0, 0, 0, 0, -1);
    add(1, 0, 4'b1111, 32'h1000_0004, 32'h0,         32'h0000_00A5, 2'b00, 10, 0,  0, 0, 0, 5, -1);
    add(2, 1, 4'b1111, 32'h2000_0008, 32'h0102_0304, 32'h0,         2'b00, 20, 3,  0, 0, 0, 0, -1);
    add(3, 0, 4'b1111, 32'h1000_0010, 32'h0,         32'h1234_5678, 2'b10, 28, 0,  0, 1, 0, 1, -1);
    add(4, 1, 4'b1100, 32'h1000_0014, 32'hCAFE_F00D, 32'h0,         2'b11, 34, 1,  2, 0, 2, 0, -1);
    add(5, 1, 4'b1111, 32'h1000_0018, 32'h0BAD_0BAD, 32'h0,         2'b00, 44, 50, 0, 0, 0, 0, 47);
    add(6, 0, 4'b1111, 32'h3000_0002, 32'h0,         32'h5555_AAAA, 2'b00, 49, 0,  0, 0, 0, 0, -1);
    add(7, 1, 4'b0001, 32'h1000_0020, 32'h1111_1111, 32'h0,         2'b00, 54, 0,  0, 0, 0, 0, -1);
    add(8, 1, 4'b0010, 32'h1000_0024, 32'h2222_2222, 32'h0,         2'b00, 54, 0,  0, 0, 0, 0, -1);
    add(9, 1, 4'b0100, 32'h1000_0028, 32'h3333_3333, 32'h0,         2'b01, 54, 0,  0, 0, 0, 0, -1);
    build_model();
    i = 0;
    while (cyc < END_C) begin
      @(negedge clk);
      rst = rst_at[cyc];
      phantom = (cyc == PHANTOM_C);
      if (phantom) begin
        data_req_i = 1'b1; data_we_i = 1'b1; data_be_i = 4'hF;
        data_addr_i = 32'h4000_0000; data_wdata_i = 32'hFFFF_0000;
      end else if (i < NT && cyc >= tx[i].start && !rst_at[cyc]) begin
        data_req_i = 1'b1; data_we_i = tx[i].we; data_be_i = tx[i].be;
        data_addr_i = tx[i].addr; data_wdata_i = tx[i].wdata;
      end else begin
        data_req_i = 1'b0;
      end
      #1;
      if (!phantom && data_req_i && data_gnt_o) begin
        sl_idx = i;
        i++;
      end
    end
    chk("all_granted", 32'(i), 32'(NT));
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
